// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared definitions for the MEM-stage data-memory responder:
//            RV32 load/store func3 encodings, responder FSM state encoding
//            and the byte-enable width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

   // RV32 load/store func3 encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Byte lanes per 32-bit word
   localparam int BE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_if
// Purpose  : MEM-stage <-> data-memory responder bus.
// Ports    : master modport (pipeline MEM stage) drives address, write_data,
//            mem_write, mem_read, func3 and receives read_data, busy,
//            misalign. slave modport (responder) is the mirror image.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_if;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        mem_write;
   logic        mem_read;
   logic [2:0]  func3;
   logic [31:0] read_data;
   logic        busy;
   logic        misalign;

   modport master (
      output address, write_data, mem_write, mem_read, func3,
      input  read_data, busy, misalign
   );

   modport slave (
      input  address, write_data, mem_write, mem_read, func3,
      output read_data, busy, misalign
   );
endinterface
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_align
// Purpose  : Combinational RV32 byte-lane steering. Maps func3 + addr[1:0]
//            to a 4-bit byte enable with lane-replicated store data, and
//            maps a raw storage word to the sign/zero-extended load result.
//            Build macro DMEM_MISALIGN_TRAP_EN: when defined, misaligned
//            half/word accesses raise `misaligned`, drop all byte enables
//            and force the load result to 0. When undefined, low address
//            bits above the access size are ignored.
// Ports    : func3        in  3   access size/sign
//            addr_lo      in  2   byte offset within word
//            store_data   in  32  rs2 store data
//            raw_word     in  32  word read from storage
//            byte_en      out 4   lane write enables
//            store_lanes  out 32  store data replicated onto all lanes
//            load_data    out 32  extended load result
//            misaligned   out 1   misaligned access detected
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]      func3,
   input  logic [1:0]      addr_lo,
   input  logic [31:0]     store_data,
   input  logic [31:0]     raw_word,
   output logic [BE_W-1:0] byte_en,
   output logic [31:0]     store_lanes,
   output logic [31:0]     load_data,
   output logic            misaligned
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = raw_word[{addr_lo, 3'b000} +: 8];
   // Halfword lane uses A[1] only; A[0] is ignored unless trapping.
   assign w_half = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];

   always_comb begin
      misaligned = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      case (func3)
         F3_H, F3_HU: misaligned = addr_lo[0];
         F3_W:        misaligned = |addr_lo;
         default:     misaligned = 1'b0;
      endcase
`endif
   end

   // Store data is replicated so each enabled lane already sees its bytes.
   always_comb begin
      byte_en     = '0;
      store_lanes = store_data;
      case (func3)
         F3_B: begin
            byte_en     = BE_W'(1) << addr_lo;
            store_lanes = {4{store_data[7:0]}};
         end
         F3_H: begin
            byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
            store_lanes = {2{store_data[15:0]}};
         end
         F3_W: begin
            byte_en     = 4'b1111;
            store_lanes = store_data;
         end
         default: byte_en = '0;
      endcase
      if (misaligned) begin
         byte_en = '0;
      end
   end

   always_comb begin
      load_data = 32'h0;
      case (func3)
         F3_B:    load_data = {{24{w_byte[7]}}, w_byte};
         F3_BU:   load_data = {24'h0, w_byte};
         F3_H:    load_data = {{16{w_half[15]}}, w_half};
         F3_HU:   load_data = {16'h0, w_half};
         F3_W:    load_data = raw_word;
         default: load_data = 32'h0;
      endcase
      if (misaligned) begin
         load_data = 32'h0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Responder side of the MEM-stage data-memory interface. Accepts
//            one load/store per request, services it over a fixed
//            LATENCY-cycle access, and holds BUSY so the pipeline keeps its
//            MEM inputs stable. Optional build macro DMEM_MISALIGN_TRAP_EN
//            enables misaligned-access trapping (see dmem_lane_align).
// Ports    : clk    in  1  clock, rising edge
//            rst_n  in  1  reset, asynchronous, active-low
//            bus    dmem_if.slave  request/response bus
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int ADDR_W      = 8,
   parameter int LATENCY     = 2
) (
   input  logic   clk,
   input  logic   rst_n,
   dmem_if.slave  bus
);

   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_t              r_state;
   state_t              w_state_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_next;
   logic                w_busy;
   logic                w_req;
   logic                w_accept;
   logic                w_last;

   // Request captured on IDLE->ACCESS; only the bits that select a word
   // and a lane are kept, which is what makes the address wrap.
   logic [ADDR_W+1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic [2:0]          r_func3;
   logic                r_wr;
   logic                r_rd;

   logic [31:0]         r_read_data;
   logic                r_misalign;

   logic [31:0]         r_mem [DEPTH_WORDS];
   logic [ADDR_W-1:0]   w_idx;
   logic [31:0]         w_raw;
   logic [BE_W-1:0]     w_be;
   logic [31:0]         w_store_lanes;
   logic [31:0]         w_load;
   logic                w_mis;

   assign w_req    = bus.mem_read | bus.mem_write;
   assign w_accept = (r_state == ST_IDLE) && w_req;
   assign w_last   = (r_state == ST_ACCESS) && (r_cnt == CNT_W'(LATENCY - 1));
   assign w_idx    = r_addr[ADDR_W+1:2];
   assign w_raw    = r_mem[w_idx];

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_busy       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_busy = w_req;
            if (w_req) begin
               w_state_next = ST_ACCESS;
               w_cnt_next   = '0;
            end
         end
         ST_ACCESS: begin
            w_busy = 1'b1;
            if (w_last) begin
               w_state_next = ST_DONE;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next   = r_cnt + CNT_W'(1);
            end
         end
         // BUSY low here lets the pipeline advance; inputs are not sampled.
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Request capture and response registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr      <= '0;
         r_wdata     <= '0;
         r_func3     <= '0;
         r_wr        <= 1'b0;
         r_rd        <= 1'b0;
         r_read_data <= 32'h0;
         r_misalign  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr  <= bus.address[ADDR_W+1:0];
            r_wdata <= bus.write_data;
            r_func3 <= bus.func3;
            r_wr    <= bus.mem_write;
            r_rd    <= bus.mem_read;
         end
         // MISALIGN is a one-cycle pulse covering DONE only.
         r_misalign <= w_last & w_mis;
         // Simultaneous read+write is serviced as a store only.
         if (w_last && r_rd && !r_wr) begin
            r_read_data <= w_load;
         end
      end
   end

   // Storage is deliberately not reset. An async reset mid-access forces
   // IDLE, so w_last cannot fire and the aborted store never commits.
   always_ff @(posedge clk) begin
      if (w_last && r_wr) begin
         for (int i = 0; i < BE_W; i++) begin
            if (w_be[i]) begin
               r_mem[w_idx][8*i +: 8] <= w_store_lanes[8*i +: 8];
            end
         end
      end
   end

   dmem_lane_align u_lane_align (
      .func3       (r_func3),
      .addr_lo     (r_addr[1:0]),
      .store_data  (r_wdata),
      .raw_word    (w_raw),
      .byte_en     (w_be),
      .store_lanes (w_store_lanes),
      .load_data   (w_load),
      .misaligned  (w_mis)
   );

   assign bus.busy      = w_busy;
   assign bus.read_data = r_read_data;
   assign bus.misalign  = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Directed self-checking bench for dmem_responder (LATENCY=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
   import dmem_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   dmem_if bus ();

   dmem_responder #(
      .DEPTH_WORDS (256),
      .ADDR_W      (8),
      .LATENCY     (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request at a negedge, count BUSY cycles until DONE, check
   // the DONE-cycle MISALIGN and that it drops the cycle after.
   task automatic do_req(input string tag, input logic wr, input logic rd,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic exp_mis);
      int n;
      bus.address    = a;
      bus.write_data = d;
      bus.func3      = f3;
      bus.mem_write  = wr;
      bus.mem_read   = rd;
      #1;
      n = 0;
      while (bus.busy === 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk({tag, "_busy_cycles"}, 32'(n), 32'd3);
      chk({tag, "_mis_done"}, {31'h0, bus.misalign}, {31'h0, exp_mis});
      bus.mem_write = 1'b0;
      bus.mem_read  = 1'b0;
      @(negedge clk);
      chk({tag, "_mis_after"}, {31'h0, bus.misalign}, 32'h0);
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      rst_n          = 1'b0;
      bus.address    = '0;
      bus.write_data = '0;
      bus.func3      = '0;
      bus.mem_write  = 1'b0;
      bus.mem_read   = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_rdata", bus.read_data, 32'h0);
      chk("rst_busy", {31'h0, bus.busy}, 32'h0);
      chk("rst_mis", {31'h0, bus.misalign}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // SW then LW
      do_req("sw10", 1'b1, 1'b0, F3_W, 32'h10, 32'hDEADBEEF, 1'b0);
      chk("rdata_hold_after_sw", bus.read_data, 32'h0);
      do_req("lw10", 1'b0, 1'b1, F3_W, 32'h10, 32'h0, 1'b0);
      chk("lw10", bus.read_data, 32'hDEADBEEF);

      // Byte store and loads
      do_req("sw10z", 1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b0);
      do_req("sb13", 1'b1, 1'b0, F3_B, 32'h13, 32'h00000080, 1'b0);
      do_req("lb13", 1'b0, 1'b1, F3_B, 32'h13, 32'h0, 1'b0);
      chk("lb13", bus.read_data, 32'hFFFFFF80);
      do_req("lbu13", 1'b0, 1'b1, F3_BU, 32'h13, 32'h0, 1'b0);
      chk("lbu13", bus.read_data, 32'h00000080);
      do_req("lw10b", 1'b0, 1'b1, F3_W, 32'h10, 32'h0, 1'b0);
      chk("lw10_after_sb", bus.read_data, 32'h80000000);

      // Halfword store and loads
      do_req("sw20z", 1'b1, 1'b0, F3_W, 32'h20, 32'h0, 1'b0);
      do_req("sh22", 1'b1, 1'b0, F3_H, 32'h22, 32'h00008001, 1'b0);
      do_req("lh22", 1'b0, 1'b1, F3_H, 32'h22, 32'h0, 1'b0);
      chk("lh22", bus.read_data, 32'hFFFF8001);
      do_req("lhu22", 1'b0, 1'b1, F3_HU, 32'h22, 32'h0, 1'b0);
      chk("lhu22", bus.read_data, 32'h00008001);
      do_req("lw20", 1'b0, 1'b1, F3_W, 32'h20, 32'h0, 1'b0);
      chk("lw20_after_sh", bus.read_data, 32'h80010000);

      // Reset during ACCESS aborts the store
      do_req("sw30", 1'b1, 1'b0, F3_W, 32'h30, 32'h11111111, 1'b0);
      bus.address    = 32'h30;
      bus.write_data = 32'h12345678;
      bus.func3      = F3_W;
      bus.mem_write  = 1'b1;
      @(negedge clk);
      chk("mid_state_access", {30'h0, dut.r_state}, {30'h0, ST_ACCESS});
      #1;
      rst_n         = 1'b0;
      bus.mem_write = 1'b0;
      #1;
      chk("mid_rst_rdata", bus.read_data, 32'h0);
      chk("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
      chk("mid_rst_mis", {31'h0, bus.misalign}, 32'h0);
      chk("mid_rst_state", {30'h0, dut.r_state}, {30'h0, ST_IDLE});
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_req("lw30", 1'b0, 1'b1, F3_W, 32'h30, 32'h0, 1'b0);
      chk("lw30_after_abort", bus.read_data, 32'h11111111);

      // Address wrap: 0x410 maps to word index 4 (byte 0x10)
      do_req("sw410", 1'b1, 1'b0, F3_W, 32'h410, 32'hAAAA5555, 1'b0);
      do_req("lw10w", 1'b0, 1'b1, F3_W, 32'h10, 32'h0, 1'b0);
      chk("wrap_lw10", bus.read_data, 32'hAAAA5555);

      // Read+write together is a store only
      do_req("rw50", 1'b1, 1'b1, F3_W, 32'h50, 32'h0BADF00D, 1'b0);
      chk("rw_rdata_hold", bus.read_data, 32'hAAAA5555);
      do_req("lw50", 1'b0, 1'b1, F3_W, 32'h50, 32'h0, 1'b0);
      chk("lw50", bus.read_data, 32'h0BADF00D);

      // Unsupported func3: no write, load returns 0
      do_req("st011", 1'b1, 1'b0, 3'b011, 32'h50, 32'hFFFFFFFF, 1'b0);
      do_req("ld011", 1'b0, 1'b1, 3'b011, 32'h50, 32'h0, 1'b0);
      chk("ld011_zero", bus.read_data, 32'h0);
      do_req("lw50b", 1'b0, 1'b1, F3_W, 32'h50, 32'h0, 1'b0);
      chk("lw50_after_bad_store", bus.read_data, 32'h0BADF00D);

      // Misaligned accesses
      do_req("sw40", 1'b1, 1'b0, F3_W, 32'h40, 32'h01020304, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
      do_req("sw41", 1'b1, 1'b0, F3_W, 32'h41, 32'hCAFEF00D, 1'b1);
      do_req("lw40", 1'b0, 1'b1, F3_W, 32'h40, 32'h0, 1'b0);
      chk("lw40_after_misaligned_sw", bus.read_data, 32'h01020304);
      do_req("lh23", 1'b0, 1'b1, F3_H, 32'h23, 32'h0, 1'b1);
      chk("lh23_misaligned", bus.read_data, 32'h0);
`else
      do_req("sw41", 1'b1, 1'b0, F3_W, 32'h41, 32'hCAFEF00D, 1'b0);
      do_req("lw40", 1'b0, 1'b1, F3_W, 32'h40, 32'h0, 1'b0);
      chk("lw40_after_misaligned_sw", bus.read_data, 32'hCAFEF00D);
      do_req("lh23", 1'b0, 1'b1, F3_H, 32'h23, 32'h0, 1'b0);
      chk("lh23_upper_half", bus.read_data, 32'hFFFF8001);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
